// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sequencing two requesters onto one shared signed ALU
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [6:0]        req0_cmd,
  input  logic [6:0]        req1_cmd,
  input  logic signed [4:0] req0_A,
  input  logic signed [4:0] req0_B,
  input  logic signed [4:0] req1_A,
  input  logic signed [4:0] req1_B,
  output logic              ALU_en,
  output logic              a_en,
  output logic              b_en,
  output logic [2:0]        a_op,
  output logic [1:0]        b_op,
  output logic signed [4:0] A,
  output logic signed [4:0] B,
  input  logic signed [5:0] c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic signed [5:0] rsp_c,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t                r_state;
  logic                  r_last;
  logic                  r_id;
  logic [2:0]            r_cnt;
  logic                  w_win;
  logic [6:0]            w_cmd;
  logic signed [4:0]     w_A;
  logic signed [4:0]     w_B;
  // winner is the lone valid requester, or the one not served last on a tie
  always_comb begin
    w_win = &req_valid ? ~r_last : req_valid[1];
    w_cmd = w_win ? req1_cmd : req0_cmd;
    w_A = w_win ? req1_A : req0_A;
    w_B = w_win ? req1_B : req0_B;
    req_ready = (r_state == IDLE && |req_valid) ? (w_win ? 2'b10 : 2'b01) : 2'b00;
  end
  assign busy = r_state != IDLE;
  // sequencer: accept, pulse ALU_en, count latency, capture c, hold response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_last <= 1'b1;
      r_id <= 1'b0;
      r_cnt <= 3'd0;
      ALU_en <= 1'b0;
      a_en <= 1'b0;
      b_en <= 1'b0;
      a_op <= 3'd0;
      b_op <= 2'd0;
      A <= 5'sd0;
      B <= 5'sd0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_c <= 6'sd0;
    end else
      case (r_state)
        IDLE:
          if (|req_valid) begin
            {a_en, b_en, a_op, b_op} <= w_cmd;
            A <= w_A;
            B <= w_B;
            r_id <= w_win;
            ALU_en <= 1'b1;
            r_state <= ISSUE;
          end
        ISSUE: begin
          ALU_en <= 1'b0;
          a_en <= 1'b0;
          b_en <= 1'b0;
          r_cnt <= 3'(ALU_LAT);
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            rsp_c <= c;
            rsp_id <= r_id;
            rsp_valid <= 1'b1;
            r_state <= RESP;
          end
        end
        default:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_last <= rsp_id;
            r_state <= IDLE;
          end
      endcase
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter at ALU_LAT 1 and 3
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] rv = 2'b00, rr, rv3 = 2'b00, rr3;
  logic [6:0] c0 = 7'd0, c1 = 7'd0, c03 = 7'd0;
  logic signed [4:0] a0 = 5'sd0, b0 = 5'sd0, a1 = 5'sd0, b1 = 5'sd0, a03 = 5'sd0, b03 = 5'sd0;
  logic en, ae, be, rspv, rid, busy, en3, ae3, be3, rspv3, rid3, busy3;
  logic rspr = 1'b1, rspr3 = 1'b1;
  logic [2:0] aop, aop3;
  logic [1:0] bop, bop3;
  logic signed [4:0] A, B, A3, B3;
  logic signed [5:0] c, c3, rc, rc3;
  logic [3:0] sh1 = 4'd0, sh3 = 4'd0;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  // ALU models: sum is only presented in the cycle ALU_LAT after ALU_en, garbage otherwise
  always @(posedge clk) begin
    sh1 <= {sh1[2:0], en};
    sh3 <= {sh3[2:0], en3};
  end
  assign c = sh1[0] ? {A[4], A} + {B[4], B} : 6'sb010101;
  assign c3 = sh3[2] ? {A3[4], A3} + {B3[4], B3} : 6'sb010101;

  alu_arbiter #(.ALU_LAT(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(rv), .req_ready(rr), .req0_cmd(c0), .req1_cmd(c1),
    .req0_A(a0), .req0_B(b0), .req1_A(a1), .req1_B(b1), .ALU_en(en), .a_en(ae), .b_en(be),
    .a_op(aop), .b_op(bop), .A(A), .B(B), .c(c), .rsp_valid(rspv), .rsp_ready(rspr),
    .rsp_id(rid), .rsp_c(rc), .busy(busy));

  alu_arbiter #(.ALU_LAT(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rr3), .req0_cmd(c03), .req1_cmd(7'd0),
    .req0_A(a03), .req0_B(b03), .req1_A(5'sd0), .req1_B(5'sd0), .ALU_en(en3), .a_en(ae3), .b_en(be3),
    .a_op(aop3), .b_op(bop3), .A(A3), .B(B3), .c(c3), .rsp_valid(rspv3), .rsp_ready(rspr3),
    .rsp_id(rid3), .rsp_c(rc3), .busy(busy3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    @(negedge clk); #1;
    check("rst_u1", {rr, en, ae, be, aop, bop, A, B, rspv, rid, rc, busy}, 32'd0);
    check("rst_u3", {rr3, en3, ae3, be3, aop3, bop3, A3, B3, rspv3, rid3, rc3, busy3}, 32'd0);
    @(negedge clk); rst = 1'b0;
    // lone req1 granted even though last starts at 1
    @(negedge clk); rv = 2'b10; c1 = 7'b0110111; a1 = 5'sd7; b1 = -5'sd2; #1;
    check("wc_ready", rr, 2'b10);
    @(negedge clk); rv = 2'b00; #1;
    check("wc_en", {en, ae, be, aop, bop}, {3'b101, 3'b101, 2'b11});
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("wc_rsp", {rspv, rid, $unsigned(rc)}, {2'b11, 6'd5});
    // req1 served, req1 alone again: granted immediately, then stalled in RESP
    @(negedge clk); rv = 2'b10; a1 = -5'sd8; b1 = -5'sd8; rspr = 1'b0; #1;
    check("wc2_ready", rr, 2'b10);
    @(negedge clk); rv = 2'b00; #1;
    @(negedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); rv = 2'b11; #1;
      check("bp_hold", {rspv, rid, $unsigned(rc), rr, en}, {2'b11, 6'b110000, 3'b000});
    end
    @(negedge clk); rv = 2'b00; rspr = 1'b1; #1;
    check("bp_release", {rspv, busy}, 2'b11);
    @(negedge clk); #1;
    check("bp_idle", {rspv, busy}, 2'b00);
    // single req0 command, ALU_LAT=1
    @(negedge clk); rv = 2'b01; c0 = 7'b1000000; a0 = 5'sd5; b0 = 5'sd3; #1;
    check("s_ready", {rr, busy}, 3'b010);
    @(negedge clk); rv = 2'b00; #1;
    check("s_issue", {en, ae, $unsigned(A), $unsigned(B), busy}, {2'b11, 5'd5, 5'd3, 1'b1});
    @(negedge clk); #1;
    check("s_wait", {en, ae, rspv, $unsigned(A)}, {3'b000, 5'd5});
    @(negedge clk); #1;
    check("s_rsp", {rspv, rid, $unsigned(rc)}, {2'b10, 6'd8});
    @(negedge clk); #1;
    check("s_done", {rspv, busy}, 2'b00);
    // reset during WAIT drops the command; last is back to 1 afterwards
    @(negedge clk); rv = 2'b01; a0 = 5'sd1; b0 = 5'sd2; #1;
    @(negedge clk); rv = 2'b00; #1;
    @(negedge clk); #1; rst = 1'b1; #1;
    check("mid_rst", {rr, en, ae, be, aop, bop, A, B, rspv, rid, rc, busy}, 32'd0);
    @(negedge clk); #1;
    check("mid_norsp", {rspv, busy}, 2'b00);
    @(negedge clk); rst = 1'b0; rv = 2'b11; c1 = 7'b0100001; a1 = -5'sd4; b1 = -5'sd5; #1;
    // continuous tie: grants alternate 0,1,0,1 and ALU_en every 4 cycles
    for (int t = 0; t < 16; t++) begin
      if (t > 0) begin
        @(negedge clk); #1;
      end
      check("rr_ready", rr, (t % 4 == 0) ? (((t / 4) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00);
      check("rr_en", en, t % 4 == 1);
      if (t % 4 == 3)
        check("rr_rsp", {rspv, rid, $unsigned(rc)},
              ((t / 4) % 2 == 1) ? {2'b11, 6'b110111} : {2'b10, 6'd3});
    end
    @(negedge clk); rv = 2'b00;
    // negative extremes at ALU_LAT=3
    @(negedge clk); rv3 = 2'b01; c03 = 7'b1000000; a03 = -5'sd16; b03 = -5'sd16; #1;
    check("neg_ready", rr3, 2'b01);
    for (int k = 1; k < 7; k++) begin
      @(negedge clk); rv3 = 2'b00; #1;
      check("neg_en", en3, k == 1);
      check("neg_valid", rspv3, k == 5);
      if (k == 5) check("neg_rsp", {rid3, $unsigned(rc3)}, {1'b0, 6'b100000});
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one signed 5-bit ALU between two command requesters. It sits between the requesters and the ALU pins (`ALU_en`, `a_en`, `b_en`, `a_op`, `b_op`, `A`, `B`, `c`). It accepts one command at a time through a valid/ready handshake and issues it to the ALU as a single-cycle `ALU_en` pulse. It then captures the 6-bit result after a fixed latency and returns it, tagged with the requester ID, through a valid/ready response port.

## Interface
Parameters:
- `ALU_LAT`, 1, cycles from the ALU_en-high cycle to the cycle in which `c` is valid; legal range 1..4.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  bit i = requester i has a command.
- `req_ready`  out  2  bit i = command i accepted this cycle (one-hot or zero).
- `req0_cmd`, `req1_cmd`  in  7  {a_en, b_en, a_op[2:0], b_op[1:0]}.
- `req0_A`, `req0_B`, `req1_A`, `req1_B`  in  5 signed  operands.
- `ALU_en`, `a_en`, `b_en`  out  1  ALU strobes.
- `a_op`  out  3;  `b_op`  out  2  ALU opcodes.
- `A`, `B`  out  5 signed  ALU operands.
- `c`  in  6 signed  ALU result.
- `rsp_valid`  out  1;  `rsp_ready`  in  1  response handshake.
- `rsp_id`  out  1  requester that issued the result.
- `rsp_c`  out  6 signed  captured result.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If no `req_valid` bit is set, stay in IDLE.
  - Otherwise pick a winner. If only one requester is valid, it wins. If both are valid, the requester other than `last` wins.
  - Assert `req_ready[winner]` combinationally in this same cycle.
  - Latch the winner's cmd, A, B and ID into holding registers, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Registered outputs drive `ALU_en`=1 together with `a_en`, `b_en`, `a_op`, `b_op`, `A`, `B` from the holding registers.
  - Load `lat_cnt` = ALU_LAT, then go to WAIT.
- WAIT:
  - `ALU_en`, `a_en` and `b_en` are 0. `a_op`, `b_op`, `A` and `B` hold their issued values.
  - `lat_cnt` decrements each cycle.
  - In the cycle where `lat_cnt`==1, `c` is sampled into `rsp_c` at the closing edge, and the FSM goes to RESP.
- RESP:
  - `rsp_valid`=1. `rsp_id` and `rsp_c` stay stable until `rsp_valid && rsp_ready`.
  - On that handshake: set `last` = `rsp_id` and go to IDLE.
- `req_ready` is 0 in every state other than IDLE, so there is never more than one command outstanding.
- Commands with `a_en`=`b_en`=0 are issued unchanged; the block does not check or decode opcodes.
- Width rule: `c` is captured verbatim as 6-bit signed. The block performs no sign extension and no saturation.
- Round-robin is work-conserving: a lone valid requester is always granted, regardless of `last`.

## Timing
- Reset state (asserted asynchronously, effective immediately):
  - FSM = IDLE, `last`=1 (so req0 wins the first tie).
  - All outputs are 0: `req_ready`, `ALU_en`, `a_en`, `b_en`, `a_op`, `b_op`, `A`, `B`, `rsp_valid`, `rsp_id`, `rsp_c`, `busy`.
- Reset deassertion: the FSM may accept a command on the first posedge after `rst` falls.
- Reset mid-operation:
  - Any in-flight command is dropped and no response is produced.
  - `last` returns to 1.
- Latency with accept in cycle 0:
  - `ALU_en`=1 in cycle 1.
  - `rsp_valid`=1 from cycle 2+ALU_LAT.
- Throughput with `rsp_ready` tied high: one command per 3+ALU_LAT cycles.
- Response stall: while `rsp_valid && !rsp_ready`, all outputs are frozen and no new grant is made.
- Requester-side simultaneous events:
  - A `req_valid` bit that drops before acceptance is simply not granted.
  - A requester may change its cmd or operands freely until its `req_ready` is seen.

## Test plan
- Single request, ALU_LAT=1: req0 sends cmd a_op=0, b_op=0, a_en=1, A=5, B=3, and the ALU model drives c=8.
  - `req_ready`=01 in cycle 0.
  - `ALU_en`=1 for cycle 1 only, with A=5 and B=3.
  - `rsp_valid`=1 in cycle 3 with `rsp_id`=0 and `rsp_c`=8.
- Both requesters hold `req_valid`=11 for 4 commands with `rsp_ready`=1.
  - Grant order is 0,1,0,1.
  - `ALU_en` pulses are exactly 4 cycles apart.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles in RESP.
  - `rsp_c` and `rsp_id` are stable throughout.
  - `req_ready` stays 00 and there is no extra `ALU_en`.
  - Releasing `rsp_ready` returns the FSM to IDLE on the next edge.
- Negative extremes, ALU_LAT=3: A=-16, B=-16, and the model drives c=-32.
  - `rsp_c`=6'b100000.
  - `rsp_valid` rises 5 cycles after the accept.
- Reset mid-operation: assert `rst` during WAIT.
  - All outputs go to 0 within the same cycle and no response appears.
  - After release with `req_valid`=11, req0 is granted first.
- Work-conserving grant: after req1 is served, req1 alone is valid. req1 is granted immediately (`req_ready`=10).
